debounce_edge: RTL and testbench
================================

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter STABLE_CNT, default 4, SHALL set the stability window; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16, SHALL set the dwell-counter width.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port din  input  1  raw, asynchronous, bouncing switch level.
REQ-007 Port q  output  1  debounced level; drives the d input of the downstream D flip-flop stage.
REQ-008 Port nq  output  1  complement of q.
REQ-009 Port rise  output  1  one-cycle pulse on a q 0->1 transition.
REQ-010 Port fall  output  1  one-cycle pulse on a q 1->0 transition.

Function
REQ-011 Define s as din after the input stage (see Configuration).
REQ-012 The FSM SHALL have four states: LOW, WAIT_HI, HIGH, WAIT_LO.
REQ-013 LOW: if s==1, go to WAIT_HI with cnt<=0; otherwise hold.
REQ-014 WAIT_HI: if s==0, return to LOW; else if cnt==STABLE_CNT-1, go to HIGH with q<=1 and rise<=1; otherwise cnt<=cnt+1.
REQ-015 HIGH and WAIT_LO SHALL mirror REQ-013 and REQ-014 with polarity inverted, driving q<=0 and fall<=1.
REQ-016 q SHALL change only after s has held its new value for STABLE_CNT+1 consecutive clock edges.
REQ-017 Any opposite sample during a WAIT state SHALL abort the wait, leave q unchanged and assert no pulse.
REQ-018 rise and fall SHALL each be high for exactly one cycle, registered, and coincident with the edge on which q updates.
REQ-019 rise and fall SHALL never be high in the same cycle.
REQ-020 nq SHALL equal ~q in every cycle, including during reset.
REQ-021 cnt SHALL never exceed STABLE_CNT-1, so it never wraps.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL force state=LOW, cnt=0, q=0, nq=1, rise=0, fall=0, and clear all input-stage flops to 0.
REQ-023 rst SHALL take priority over all other events and SHALL abort any WAIT in progress without generating a pulse.
REQ-024 After rst is released, if din==1, a rise SHALL follow only after the full latency of REQ-027.

Configuration
REQ-025 Macro DEBOUNCE_SYNC_EN, when defined, SHALL place a two-flop synchronizer on din; s is the second flop's output.
REQ-026 When DEBOUNCE_SYNC_EN is undefined, din SHALL pass through a single register, so s is din delayed by one cycle.
REQ-027 Latency from a stable din change to the q change SHALL be STABLE_CNT+3 edges with the macro defined and STABLE_CNT+2 edges without it.

Structure
REQ-028 Package debounce_pkg SHALL hold the state enumeration typedef (LOW, WAIT_HI, HIGH, WAIT_LO; 2-bit encoding) and the default STABLE_CNT and CNT_W constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync2 (clk, rst, d, q), instantiated only under DEBOUNCE_SYNC_EN.
REQ-030 The FSM and dwell counter SHALL reside in debounce_edge itself.

Verification (STABLE_CNT=4, DEBOUNCE_SYNC_EN defined)
REQ-031 Reset: rst=1 for 2 cycles with din=1 -> q=0, nq=1, rise=0, fall=0 throughout reset.
REQ-032 Clean rise: din 0->1 and held -> q=1 exactly 7 edges later, rise=1 on that single cycle, nq=0.
REQ-033 Bounce: din toggles 1,0,1,0 on successive cycles, then stays 0 -> q stays 0, no rise or fall pulse.
REQ-034 Short glitch: from q=1, din=0 for 4 cycles then back to 1 -> q stays 1, fall never asserts.
REQ-035 Reset mid-wait: din=1 held, rst pulsed at edge 5 -> q=0 and no rise at edge 7; rise occurs 7 edges after rst is released.
REQ-036 Without macro: repeat the REQ-032 stimulus -> q=1 exactly 6 edges after the din change.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce_edge block.
// State encoding is fixed at 2 bits so the FSM register stays compact.
package debounce_pkg;
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam int DEF_STABLE_CNT = 4;
    localparam int DEF_CNT_W      = 16;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the raw switch input; both flops clear on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule

// File: rtl/debounce_edge.sv
// Switch debouncer with registered rise/fall pulses. Define DEBOUNCE_SYNC_EN
// to put a two-flop synchronizer (sync2) in front of the FSM instead of one register.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic nq,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

`ifdef DEBOUNCE_SYNC_EN
    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s)
    );
`else
    logic r_din;

    always_ff @(posedge clk) begin
        if (rst) r_din <= 1'b0;
        else     r_din <= din;
    end

    assign w_s = r_din;
`endif

    // Pulses default low so each one lasts exactly the cycle q updates on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_s) begin
                        r_state <= LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HIGH;
                        r_q     <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (w_s) begin
                        r_state <= HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                        r_q     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= LOW;
            endcase
        end
    end

    // nq is combinational from r_q so it tracks ~q even while reset is held.
    assign q    = r_q;
    assign nq   = ~r_q;
    assign rise = r_rise;
    assign fall = r_fall;
endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge (STABLE_CNT=4); expected latency follows
// whether DEBOUNCE_SYNC_EN is defined for the build.
module tb_debounce_edge;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic q, nq, rise, fall;
    int   total = 0;
    int   bad   = 0;

    debounce_edge #(.STABLE_CNT(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .nq   (nq),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic eq, input logic er, input logic ef);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".nq"}, nq, ~eq);
        chk({tag, ".rise"}, rise, er);
        chk({tag, ".fall"}, fall, ef);
    endtask

    initial begin
        // reset with din high
        rst = 1'b1;
        din = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_all("reset", 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        din = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0, 1'b0);
        end

        // clean rise
        din = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk_all($sformatf("rise_k%0d", k), (k >= LAT), (k == LAT), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("high_hold", 1'b1, 1'b0, 1'b0);
        end

        // short low glitch from q=1
        din = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("glitch_lo", 1'b1, 1'b0, 1'b0);
        end
        din = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_all("glitch_after", 1'b1, 1'b0, 1'b0);
        end

        // clean fall
        din = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk_all($sformatf("fall_k%0d", k), (k < LAT), 1'b0, (k == LAT));
        end

        // bounce 1,0,1,0 then low
        for (int k = 0; k < 4; k++) begin
            din = (k % 2 == 0);
            tick();
            chk_all("bounce", 1'b0, 1'b0, 1'b0);
        end
        din = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_all("bounce_after", 1'b0, 1'b0, 1'b0);
        end

        // reset pulsed at edge 5 of a rising wait
        din = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_all($sformatf("midwait_k%0d", k), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk_all("midwait_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk_all($sformatf("postrst_k%0d", k), (k >= LAT), (k == LAT), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
